fetch_prefetch: RTL and testbench
=================================

// Module: fetch_prefetch
// PURPOSE
//  Parametrised instruction fetch stage with a decoupling prefetch queue. It keeps a PC register
//  and issues sequential requests to the synchronous instruction memory (1-cycle read). It buffers
//  {pc, pc+4, instr} in a DEPTH-entry FIFO and hands entries to decode over a valid/ready handshake.
//  Branch/jump redirects and interrupt vectors flush the queue and restart fetch at the new target.
// PARAMETERS
//  XLEN      32     address/instruction width
//  DEPTH     4      prefetch queue entries; power of two, >= 2
//  RESET_PC  32'h0  PC loaded on reset
// PORTS
//  clk             in   1     clock, rising edge
//  rst             in   1     reset, asynchronous, active-high
//  redirect_valid  in   1     branch/jump taken; restart fetch at redirect_addr
//  redirect_addr   in   XLEN  redirect target
//  intr_valid      in   1     interrupt taken; restart at intr_addr (priority over redirect)
//  intr_addr       in   XLEN  interrupt handler address
//  imem_req        out  1     read request this cycle
//  imem_addr       out  XLEN  read address (= pc_q)
//  imem_rdata      in   XLEN  read data, valid the cycle after an accepted imem_req
//  out_valid       out  1     queue head valid
//  out_ready       in   1     decode accepts head
//  out_pc          out  XLEN  PC of head instruction
//  out_pc_plus4    out  XLEN  out_pc + 4, truncated to XLEN bits
//  out_instr       out  XLEN  head instruction word
//  err             out  1     sticky misaligned-target flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async): pc_q=RESET_PC, queue empty, inflight=0, drop=0, out_valid=0, imem_req=0, err=0.
//    Outputs are held at these values while rst is high. Reset mid-operation discards everything.
//  - Issue: imem_req = !flush && (count + inflight < DEPTH). On issue, pc_q <= pc_q + 4 (wraps mod 2^XLEN).
//    inflight <= imem_req. A response therefore always has a free slot; no overflow.
//  - Response: in the cycle after an issue, push {issued pc, pc+4, imem_rdata} unless drop=1.
//  - Pop: when out_valid && out_ready. Push and pop in the same cycle: count is unchanged.
//  - Flush = intr_valid || redirect_valid. On the flush edge:
//    pc_q <= intr_valid ? intr_addr : redirect_addr.
//    The queue is cleared. drop <= inflight, so the stale response is discarded.
//    imem_req is 0 in the flush cycle.
//  - A handshake in the flush cycle (out_valid && out_ready) counts as completed.
//  - Redirect latency: target request issued in the cycle after the flush edge.
//    out_valid is high 2 edges after the flush edge, with out_pc = target.
//  - Back-to-back flushes: each one restarts; the last target wins.
//  - out_ready=0 indefinitely: the queue fills to DEPTH, imem_req drops to 0, and no entry is lost.
//  - Reset release: the first imem_req=1 (addr RESET_PC) occurs in the first cycle after rst deasserts.
// CONFIGURATION
//  FETCH_MISALIGN_CHECK_EN defined:
//  - A flush target with addr[1:0] != 0 sets err=1 (sticky until rst).
//  - Fetch still restarts at target with bits [1:0] cleared.
//  FETCH_MISALIGN_CHECK_EN undefined:
//  - err tied 0.
//  - Target bits [1:0] are silently cleared.
// STRUCTURE
//  - Package fetch_pkg:
//    - XLEN_DEFAULT.
//    - typedef struct fetch_entry_t {pc, pc_plus4, instr}.
//    - localparam INSTR_BYTES = 4.
//  - Sub-module fetch_fifo: parametrised DEPTH x fetch_entry_t circular buffer.
//    - Ports: push, pop, clear, full, empty, count. Pointers wrap mod DEPTH.
//    - Asynchronous reset to empty.
//  - Top level holds pc_q, the inflight/drop flags, issue logic and flush priority.
// TESTING
//  1. Reset, RESET_PC=0, out_ready=1, imem returns addr>>2 ->
//     out_pc sequence 0,4,8,C. First out_valid 2 edges after rst release.
//  2. out_ready=0 for 10 cycles, DEPTH=4 -> count reaches 4, imem_req=0.
//     Release -> entries 0,4,8,C are delivered in order with no gaps.
//  3. Redirect to 0x100 while inflight=1 and the queue holds 2 entries ->
//     both entries and the stale response are dropped. Next out_pc=0x100, then 0x104.
//  4. intr_valid (0x80) and redirect_valid (0x200) asserted in the same cycle ->
//     next out_pc=0x80.
//  5. PC 0xFFFF_FFFC streaming -> next fetch 0x0000_0000. out_pc_plus4 = 0x0 for the 0xFFFF_FFFC entry.
//  6. With FETCH_MISALIGN_CHECK_EN, redirect to 0x102 -> err=1 next edge, out_pc=0x100, err stays 1.
//     Without the macro, err stays 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int INSTR_BYTES  = 4;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] pc_plus4;
    logic [XLEN_DEFAULT-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer of DEPTH entries; clear has priority over push/pop.
// Head entry is read combinationally so a pushed entry is visible the next cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  entry_t        wr_data,
  output entry_t        rd_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign rd_data = mem[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // A full buffer can still accept a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_prefetch.sv
// Sequential instruction fetch with prefetch queue, redirect/interrupt flush.
// Optional FETCH_MISALIGN_CHECK_EN: sticky err on a flush target with addr[1:0] != 0.
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_addr,
  input  logic            intr_valid,
  input  logic [XLEN-1:0] intr_addr,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_plus4,
  output logic [XLEN-1:0] out_instr,
  output logic            err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INSTR_BYTES - 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] instr;
  } entry_t;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] raw_target;
  logic [XLEN-1:0] target;
  logic            inflight_q;
  logic            drop_q;
  logic            flush;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  entry_t          wr_entry;
  entry_t          head;

  assign flush      = intr_valid || redirect_valid;
  assign raw_target = intr_valid ? intr_addr : redirect_addr;
  assign target     = raw_target & ALIGN_MASK;

  // Slots already promised to an in-flight read count as occupied.
  assign imem_req  = !rst && !flush && !fifo_full &&
                     ((fifo_count + CW'(inflight_q)) < CW'(DEPTH));
  assign imem_addr = pc_q;

  assign push      = inflight_q && !drop_q && !flush;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  // pc_q has advanced exactly once since the request now answering was issued.
  always_comb begin
    wr_entry          = '0;
    wr_entry.pc       = pc_q - XLEN'(INSTR_BYTES);
    wr_entry.pc_plus4 = pc_q;
    wr_entry.instr    = imem_rdata;
  end

  assign out_pc       = head.pc;
  assign out_pc_plus4 = head.pc_plus4;
  assign out_instr    = head.instr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
    end else if (flush) begin
      pc_q       <= target;
      inflight_q <= 1'b0;
      drop_q     <= inflight_q;
    end else begin
      inflight_q <= imem_req;
      drop_q     <= 1'b0;
      if (imem_req) pc_q <= pc_q + XLEN'(INSTR_BYTES);
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (flush && (raw_target[1:0] != 2'b00)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .clear   (flush),
    .wr_data (wr_entry),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed + randomized bench for fetch_prefetch against a queue-based reference model.
module tb_fetch_prefetch;

  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        intr_valid = 1'b0;
  logic [31:0] intr_addr = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic [31:0] out_instr;
  logic        err;

  fetch_prefetch #(
    .XLEN     (32),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .intr_valid     (intr_valid),
    .intr_addr      (intr_addr),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4),
    .out_instr      (out_instr),
    .err            (err)
  );

  always #5 clk = ~clk;

  // Reference model: queued PCs awaiting decode, next fetch PC, outstanding read.
  logic [31:0] mq[$];
  logic [31:0] pc_m;
  bit          infl_m;
  logic [31:0] infl_addr;
  bit          err_m;
  int          total = 0;
  int          bad = 0;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a >> 2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    intr_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_imem_addr", imem_addr, RESET_PC);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    pc_m = RESET_PC;
    infl_m = 1'b0;
    err_m = 1'b0;
    $display("reset released pc=%h", RESET_PC);
  endtask

  task automatic cyc(input bit rv, input logic [31:0] ra, input bit iv,
                     input logic [31:0] ia, input bit rdy);
    bit          fl;
    bit          exp_req;
    bit          hs;
    logic [31:0] tgt_raw;
    redirect_valid = rv;
    redirect_addr  = ra;
    intr_valid     = iv;
    intr_addr      = ia;
    out_ready      = rdy;
    fl      = rv || iv;
    tgt_raw = iv ? ia : ra;
    exp_req = !fl && ((mq.size() + int'(infl_m)) < DEPTH);
    @(negedge clk);
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) chk("imem_addr", imem_addr, pc_m);
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("out_pc", out_pc, mq[0]);
      chk("out_pc_plus4", out_pc_plus4, mq[0] + 32'd4);
      chk("out_instr", out_instr, mem_f(mq[0]));
    end
    chk("err", 32'(err), 32'(err_m));
    hs = (mq.size() > 0) && rdy;
    if (hs) $display("xfer pc=%h pc4=%h instr=%h", out_pc, out_pc_plus4, out_instr);
    @(posedge clk);
    if (fl) begin
      mq.delete();
      pc_m = tgt_raw & ~32'd3;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (tgt_raw[1:0] != 2'b00) err_m = 1'b1;
`endif
      infl_m = 1'b0;
      $display("flush to %h (intr=%0d)", pc_m, iv);
    end else begin
      if (hs) void'(mq.pop_front());
      if (infl_m) mq.push_back(infl_addr);
      infl_m = exp_req;
      if (exp_req) begin
        infl_addr = pc_m;
        pc_m = pc_m + 32'd4;
      end
    end
    #1;
    imem_rdata = infl_m ? mem_f(infl_addr) : $urandom();
  endtask

  initial begin
    bit          rv;
    bit          iv;
    logic [31:0] ra;
    logic [31:0] ia;

    // 1: streaming from reset
    do_reset();
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 1);

    // 2: decode stalled, queue fills, then drains in order
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 1);

    // 3: redirect with two queued entries and one read outstanding
    do_reset();
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
    cyc(1, 32'h100, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 1);

    // 4: interrupt beats redirect
    cyc(1, 32'h200, 1, 32'h80, 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1);

    // 5: PC wrap past the top of the address space
    cyc(1, 32'hFFFF_FFF4, 0, 0, 1);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 1);

    // 6: misaligned redirect target
    cyc(1, 32'h102, 0, 0, 1);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 1);

    // back-to-back flushes, last target wins
    cyc(1, 32'h300, 0, 0, 1);
    cyc(1, 32'h400, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1);

    // randomized traffic with occasional mid-run reset
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      rv = ($urandom_range(0, 99) < 5);
      iv = ($urandom_range(0, 99) < 3);
      ra = $urandom();
      ia = $urandom();
      cyc(rv, ra, iv, ia, $urandom_range(0, 99) < 70);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
